// File: rtl/aes_cipher_core_if.sv
// Valid/ready bundle carrying plaintext into and ciphertext out of the AES cipher core.
interface aes_cipher_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;

  modport master (
    output in_valid,
    output plaintext,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  ciphertext
  );

  modport slave (
    input  in_valid,
    input  plaintext,
    input  out_ready,
    output in_ready,
    output out_valid,
    output ciphertext
  );
endinterface

// File: rtl/aes_cipher_core.sv
// Iterative AES encryption core: one full round per clock, round keys taken from the
// flat expanded schedule, valid/ready handshakes on both sides.
module aes_cipher_core #(
  parameter int NR_MAX = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                i_mode,
  input  logic [(NR_MAX+1)*128-1:0] i_round_keys,
  output logic                      o_busy,
  aes_cipher_core_if.slave          bus
);
  localparam int RK_W = (NR_MAX + 1) * 128;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] m);
    case (m)
      2'b01:   return 4'd12;
      2'b10:   return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  // Byte k sits at [127-8k]; row r of column c is byte 4c+r, and row r rotates left by r.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_data;
  logic [127:0] w_data_nxt;
  logic [127:0] r_ct;
  logic [127:0] w_ct_nxt;
  logic [3:0]   r_round;
  logic [3:0]   w_round_nxt;
  logic [3:0]   r_nr;
  logic [3:0]   w_nr_nxt;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;
  logic [127:0] w_rk_tbl [0:15];
  logic [127:0] w_rk;
  logic [127:0] w_sub_shift;
  logic [127:0] w_mixed;

  // Unused table slots read as zero so a corrupted counter cannot index past the bus.
  for (genvar g = 0; g < 16; g++) begin : g_rk
    if (g <= NR_MAX) begin : g_used
      assign w_rk_tbl[g] = i_round_keys[RK_W-1-128*g -: 128];
    end else begin : g_unused
      assign w_rk_tbl[g] = 128'h0;
    end
  end

  assign w_rk        = w_rk_tbl[r_round];
  assign w_sub_shift = sub_shift(r_data);
  assign w_mixed     = mix_columns(w_sub_shift);

  // Next-state and datapath selection for the IDLE/ROUND/DONE sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_ct_nxt    = r_ct;
    w_round_nxt = r_round;
    w_nr_nxt    = r_nr;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_state_nxt = S_ROUND;
          w_data_nxt  = bus.plaintext ^ w_rk_tbl[0];
          w_round_nxt = 4'd1;
          w_nr_nxt    = nr_of(i_mode);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ROUND: begin
        if (r_round >= r_nr) begin
          w_data_nxt  = w_sub_shift ^ w_rk;
          w_ct_nxt    = w_sub_shift ^ w_rk;
          w_state_nxt = S_DONE;
        end else begin
          w_data_nxt  = w_mixed ^ w_rk;
          w_round_nxt = r_round + 4'd1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and handshake output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_data      <= 128'h0;
      r_ct        <= 128'h0;
      r_round     <= 4'd0;
      r_nr        <= 4'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_data      <= w_data_nxt;
      r_ct        <= w_ct_nxt;
      r_round     <= w_round_nxt;
      r_nr        <= w_nr_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.ciphertext = r_ct;
  assign o_busy         = r_busy;
endmodule

// File: tb/tb_aes_cipher_core.sv
// Bench for aes_cipher_core: byte-level AES reference with S-box derived from GF(2^8)
// inverses, per-cycle output comparison, and FIPS-197 directed vectors.
module tb_aes_cipher_core;
  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     mode;
  logic [1919:0]  round_keys;
  logic           busy;
  int             cyc = 0;
  int             n_cmp = 0;
  int             n_bad = 0;
  logic [7:0]     sb [256];

  aes_cipher_core_if bus ();

  aes_cipher_core u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_mode       (mode),
    .i_round_keys (round_keys),
    .o_busy       (busy),
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [255:0] K_B   = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K_128 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K_192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  // S-box = affine transform of the multiplicative inverse in GF(2^8).
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] r;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      r = inv;
      sb[a] = 8'h63 ^ inv;
      for (int k = 0; k < 4; k++) begin
        r = rotl1(r);
        sb[a] = sb[a] ^ r;
      end
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] o;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*nk-1-32*i -: 32];
    for (int i = nk; i < 60; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 60; i++) o[1919-32*i -: 32] = w[i];
    return o;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [1919:0] rk,
                                                 input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk[1919-8*k -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) t[k] = sb[s[k]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int w = 0; w < 4; w++) a[w] = s[4*c+w];
          for (int w = 0; w < 4; w++)
            s[4*c+w] = gmul(a[w], 8'h02) ^ gmul(a[(w+1)%4], 8'h03) ^ a[(w+2)%4] ^ a[(w+3)%4];
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk[1919-128*r-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  function automatic int nr_of(input logic [1:0] m);
    if (m == 2'b01) return 12;
    if (m == 2'b10) return 14;
    return 10;
  endfunction

  // Per-cycle comparison against the transaction-level expectation.
  initial begin
    bit           pending;
    int           due;
    logic [127:0] exp_ct;
    pending = 1'b0;
    due     = 0;
    exp_ct  = 128'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        pending = 1'b0;
      end else if (!pending) begin
        chk("idle_in_ready", bus.in_ready, 1'b1);
        chk("idle_out_valid", bus.out_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
        if (bus.in_valid) begin
          pending = 1'b1;
          due     = cyc + nr_of(mode) + 1;
          exp_ct  = model_encrypt(bus.plaintext, round_keys, nr_of(mode));
        end
      end else if (cyc < due) begin
        chk("run_in_ready", bus.in_ready, 1'b0);
        chk("run_out_valid", bus.out_valid, 1'b0);
        chk("run_busy", busy, 1'b1);
      end else begin
        chk("done_in_ready", bus.in_ready, 1'b0);
        chk("done_out_valid", bus.out_valid, 1'b1);
        chk("done_busy", busy, 1'b1);
        chk("done_ct", bus.ciphertext, exp_ct);
        if (bus.out_ready) pending = 1'b0;
      end
    end
  end

  task automatic send(input logic [127:0] pt, input logic [255:0] key, input int nk,
                      input logic [1:0] md, input logic [127:0] want, input int want_lat,
                      input bit flip);
    int t_acc;
    int n;
    @(posedge clk); #1;
    round_keys    = expand(key, nk);
    mode          = md;
    bus.plaintext = pt;
    bus.in_valid  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 40);
    if (!bus.in_ready) begin
      chk("accept_timeout", 1'b0, 1'b1);
      bus.in_valid = 1'b0;
      return;
    end
    t_acc = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (flip) begin
      repeat (2) @(posedge clk);
      #1 mode = 2'b00;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 40);
    chk("out_valid_seen", bus.out_valid, 1'b1);
    chk("latency", 128'(cyc - t_acc), 128'(want_lat));
    chk("ct_literal", bus.ciphertext, want);
  endtask

  initial begin
    logic [127:0] held_ct;
    rst           = 1'b0;
    mode          = 2'b00;
    round_keys    = '0;
    bus.in_valid  = 1'b0;
    bus.plaintext = '0;
    bus.out_ready = 1'b1;
    build_sbox();
    #1 rst = 1'b1;

    chk("pin_app_b", model_encrypt(PT_B, expand(K_B, 4), 10), CT_B);
    chk("pin_c128", model_encrypt(PT_C, expand(K_128, 4), 10), CT_128);
    chk("pin_c192", model_encrypt(PT_C, expand(K_192, 6), 12), CT_192);
    chk("pin_c256", model_encrypt(PT_C, expand(K_256, 8), 14), CT_256);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(PT_B, K_B, 4, 2'b00, CT_B, 11, 1'b0);
    send(PT_C, K_128, 4, 2'b00, CT_128, 11, 1'b0);
    send(PT_C, K_192, 6, 2'b01, CT_192, 13, 1'b0);
    send(PT_C, K_256, 8, 2'b10, CT_256, 15, 1'b0);
    send(PT_C, K_128, 4, 2'b11, CT_128, 11, 1'b0);

    // Output stall: everything held until out_ready returns.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(PT_B, K_B, 4, 2'b00, CT_B, 11, 1'b0);
    held_ct = bus.ciphertext;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_ct_stable", bus.ciphertext, held_ct);
      chk("bp_in_ready", bus.in_ready, 1'b0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_out_valid", bus.out_valid, 1'b1);
    @(negedge clk);
    chk("bp_after_in_ready", bus.in_ready, 1'b1);
    chk("bp_after_out_valid", bus.out_valid, 1'b0);

    send(PT_C, K_256, 8, 2'b10, CT_256, 15, 1'b1);

    // Abort an AES-256 block in round 5, then confirm a clean restart.
    @(posedge clk); #1;
    round_keys    = expand(K_256, 8);
    mode          = 2'b10;
    bus.plaintext = PT_C;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_ready", bus.in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(PT_B, K_B, 4, 2'b00, CT_B, 11, 1'b0);

    // in_valid held high across several handshakes.
    @(posedge clk); #1;
    round_keys    = expand(K_128, 4);
    mode          = 2'b00;
    bus.plaintext = PT_C;
    bus.in_valid  = 1'b1;
    repeat (30) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (20) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_cipher_core.md
Name: aes_cipher_core

Overview:
Iterative AES encryption datapath that consumes the flat round-key bus produced by key_expansion and encrypts one 128-bit block per transaction. It performs one full AES round per clock. Valid/ready handshakes are used on the input and output sides. It sits directly downstream of key_expansion, and the top level wires key_expansion.round_keys and mode straight into it.

Parameters:
NR_MAX, 14, maximum round count supported. Sizes the round counter at 4 bits. Fixed for the AES-256 worst case.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high; clears all state immediately
mode  input  2  key size: 00=128 (Nr=10), 01=192 (Nr=12), 10=256 (Nr=14), 11 treated as 128
round_keys  input  1920  expanded schedule, word w[i] at [1919-32*i -: 32]; round key r at [1919-128*r -: 128]
in_valid  input  1  plaintext present
in_ready  output  1  core can accept a block (high only in IDLE)
plaintext  input  128  block; byte 0 at [127:120], column-major state order per FIPS-197
out_valid  output  1  ciphertext present
out_ready  input  1  downstream accepts ciphertext
ciphertext  output  128  result, same byte ordering as plaintext
busy  output  1  high in ROUND and DONE

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - State register, ciphertext and round counter go to 0.
  - out_valid=0, busy=0, in_ready=1.
  - An in-flight block is discarded, with no output.
  - in_valid is ignored while rst=1.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the core latches mode into mode_q and derives Nr from it.
  - On the same edge it loads state = plaintext ^ rk[0], sets round=1 and moves to ROUND.
- ROUND:
  - For round < Nr, each edge computes state = MixColumns(ShiftRows(SubBytes(state))) ^ rk[round], then round += 1.
  - For round == Nr, the edge computes state = ShiftRows(SubBytes(state)) ^ rk[Nr], loads ciphertext and moves to DONE.
- DONE:
  - out_valid=1 and ciphertext is held stable.
  - On an edge with out_ready=1, out_valid drops and the FSM returns to IDLE.
  - No new block is accepted in the same cycle as the output handshake.
- Latency:
  - out_valid rises Nr+1 edges after the accept edge: 11, 13 and 15 cycles for 128/192/256.
  - Minimum issue interval is Nr+2 cycles when out_ready is held high.
- Round key source:
  - Round keys are read combinationally from round_keys using the round counter.
  - Upstream must hold round_keys and mode stable from the accept edge until the output handshake. This is a contract, not a check.
  - mode is sampled only at accept; changes to mode during ROUND or DONE do not alter Nr.
- Datapath rules:
  - SubBytes uses 16 parallel S-boxes with the FIPS-197 table.
  - MixColumns uses xtime over GF(2^8) with polynomial 0x11b.
  - All arithmetic is bitwise XOR; there are no carries.
- Backpressure: while out_ready=0 in DONE, the core stalls indefinitely and keeps in_ready=0.
- Reset during ROUND or DONE: the core returns to IDLE asynchronously, and out_valid deasserts without an edge.

Test Plan:
- Bench setup: key_expansion with the key LSB-aligned (128→key[127:0], 192→key[191:0], 256→key[255:0]) feeds round_keys.
- FIPS-197 App. B: mode=00, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32, with out_valid exactly 11 cycles after accept.
- FIPS-197 App. C, all three key sizes, pt 00112233445566778899aabbccddeeff:
  - mode=00, key 000102..0f -> 69c4e0d86a7b0430d8cdb78070b4c55a.
  - mode=01, key 000102..17 -> dda97ca4864cdfe06eaf70a0ec0d7191.
  - mode=10, key 000102..1f -> 8ea2b7ca516745bfeafc49904b496089.
  - Latencies 11/13/15 respectively.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> ciphertext and out_valid stable, in_ready=0 throughout; raising out_ready -> handshake, then in_ready=1 the following cycle.
- Mode stability: flip mode from 10 to 00 two cycles after accept of an AES-256 block (round_keys held) -> 15-cycle latency, correct ct 8ea2b7ca516745bfeafc49904b496089.
- Reset mid-op: assert rst during round 5 -> out_valid=0, busy=0, in_ready=1 immediately; release, send App. B vector -> correct ct, no stale output.
- mode=11 with App. C 128-bit key -> behaves as 128-bit: ct 69c4e0d86a7b0430d8cdb78070b4c55a, latency 11.
